// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan decoder and its prescaler.
// Holds the FSM state encoding, a one-hot decode function and a clog2 helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // One-hot decode at the widest supported size; callers truncate.
    function automatic logic [MAX_OUT_W-1:0] onehot_decode(
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 active_low
    );
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Free-running divide-by-CLK_DIV tick generator with synchronous clear.
// Ports: clk, rst_n (async low), en (count), clear (to 0), tick (wrap pulse).
module clk_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);
    import scan_pkg::*;

    localparam int PW_RAW = clog2(CLK_DIV);
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    // Tick is the cycle the count sits at its last value.
    assign tick = en && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with manual select or auto-scan.
// Ports: clk, rst_n, en, auto, sel -> y (one-hot), idx, tick, sel_err.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int NUM_OUT    = 8,
    parameter int CLK_DIV    = 100000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    auto,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    tick,
    output logic                    sel_err
);
    import scan_pkg::*;

    localparam int   OUT_W  = 2**SEL_W;
    localparam logic AL     = (ACTIVE_LOW != 0);
    localparam int   BW_RAW = clog2(BLANK_CYC + 1);
    localparam int   BW     = (BW_RAW < 1) ? 1 : BW_RAW;
    localparam logic [BW-1:0] BLAST =
        BW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]   NOUT     = (SEL_W + 1)'(NUM_OUT);
    localparam logic [OUT_W-1:0] Y_OFF    = {OUT_W{AL}};
    // Where a change lands: straight to DRIVE when no blanking.
    localparam state_t POST = (BLANK_CYC == 0) ? DRIVE : BLANK;

    state_t            state;
    state_t            state_n;
    logic [SEL_W-1:0]  idx_n;
    logic [SEL_W-1:0]  nxt_idx;
    logic [BW-1:0]     bcnt;
    logic [BW-1:0]     bcnt_n;
    logic [OUT_W-1:0]  y_n;
    logic              auto_q;
    logic              toggle;
    logic              chg;
    logic              sel_ok;
    logic              p_en;
    logic              p_clear;

    assign sel_ok  = ({1'b0, sel} < NOUT);
    assign toggle  = en && (auto != auto_q);
    assign p_en    = en && auto;
    assign p_clear = !en || toggle;

    clk_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (p_en),
        .clear (p_clear),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        bcnt_n  = bcnt;
        chg     = 1'b0;
        nxt_idx = idx;

        if (auto) begin
            chg     = tick;
            nxt_idx = (idx == IDX_LAST) ? '0 : idx + SEL_W'(1);
        end else begin
            chg     = sel_ok && (sel != idx);
            nxt_idx = sel;
        end

        // Priority: disable, then mode toggle, then index change.
        if (!en) begin
            state_n = IDLE;
            bcnt_n  = '0;
        end else if (toggle) begin
            state_n = POST;
            bcnt_n  = '0;
        end else if (chg) begin
            idx_n   = nxt_idx;
            state_n = POST;
            bcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = POST;
                    bcnt_n  = '0;
                end
                BLANK: begin
                    if (bcnt == BLAST) begin
                        state_n = DRIVE;
                        bcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                    end
                end
                DRIVE: state_n = DRIVE;
                default: state_n = IDLE;
            endcase
        end

        // Decode from next-state values so y tracks idx with no lag.
        y_n = Y_OFF;
        if (state_n == DRIVE) begin
            y_n = OUT_W'(onehot_decode(MAX_SEL_W'(idx_n), AL));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            bcnt    <= '0;
            y       <= Y_OFF;
            sel_err <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            bcnt    <= bcnt_n;
            y       <= y_n;
            sel_err <= en && !auto && !sel_ok;
            auto_q  <= auto;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Randomised scoreboard bench for scan_decoder, two parameter sets.
// A countdown-style reference model predicts every cycle's outputs.
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       auto;
    logic [2:0] sel;
    logic [7:0] y0;
    logic [2:0] idx0;
    logic       tick0;
    logic       serr0;
    logic [7:0] y1;
    logic [2:0] idx1;
    logic       tick1;
    logic       serr1;

    int total = 0;
    int bad   = 0;

    scan_decoder #(
        .SEL_W(3), .NUM_OUT(6), .CLK_DIV(4), .BLANK_CYC(2), .ACTIVE_LOW(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel(sel),
        .y(y0), .idx(idx0), .tick(tick0), .sel_err(serr0)
    );

    scan_decoder #(
        .SEL_W(3), .NUM_OUT(8), .CLK_DIV(2), .BLANK_CYC(0), .ACTIVE_LOW(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel(sel),
        .y(y1), .idx(idx1), .tick(tick1), .sel_err(serr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: index, prescaler phase, blank cycles left, live flag.
    typedef struct {
        int idx;
        int ph;
        int blk;
        bit on;
        bit pa;
    } ms_t;

    typedef struct {
        logic [7:0] y0;
        logic [2:0] i0;
        logic       t0;
        logic       s0;
        logic [7:0] y1;
        logic [2:0] i1;
        logic       t1;
        logic       s1;
    } exp_t;

    exp_t q[$];
    ms_t  m0;
    ms_t  m1;

    function automatic ms_t mreset();
        ms_t m;
        m.idx = 0;
        m.ph  = 0;
        m.blk = 0;
        m.on  = 0;
        m.pa  = 0;
        return m;
    endfunction

    function automatic ms_t mstep(ms_t m, int nout, int div, int bcyc,
                                  bit e, bit a, int s);
        bit tg;
        bit tk;
        bit chg;
        tg   = e && (a != m.pa);
        m.pa = a;
        tk   = e && a && !tg && (m.ph == div - 1);
        if (!e || tg) m.ph = 0;
        else if (a) m.ph = (m.ph + 1) % div;
        if (!e) begin
            m.on = 0;
        end else if (tg) begin
            m.on  = 1;
            m.blk = bcyc;
        end else begin
            chg = a ? tk : (s < nout && s != m.idx);
            if (chg) begin
                m.idx = a ? (m.idx + 1) % nout : s;
                m.on  = 1;
                m.blk = bcyc;
            end else if (!m.on) begin
                m.on  = 1;
                m.blk = bcyc;
            end else if (m.blk > 0) begin
                m.blk = m.blk - 1;
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] my(ms_t m, bit al);
        logic [7:0] v;
        v = (m.on && m.blk == 0) ? 8'(1 << m.idx) : 8'h00;
        return al ? ~v : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit e, input bit a, input int s);
        exp_t x;
        @(negedge clk);
        #2;
        en   = e;
        auto = a;
        sel  = 3'(s);
        m0 = mstep(m0, 6, 4, 2, e, a, s);
        m1 = mstep(m1, 8, 2, 0, e, a, s);
        x.y0 = my(m0, 1'b1);
        x.i0 = 3'(m0.idx);
        x.t0 = e && a && (m0.ph == 3);
        x.s0 = e && !a && (s >= 6);
        x.y1 = my(m1, 1'b0);
        x.i1 = 3'(m1.idx);
        x.t1 = e && a && (m1.ph == 1);
        x.s1 = e && !a && (s >= 8);
        q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", 32'(q.size()), 0);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_y0"}, 32'(y0), 32'hFF);
        chk({tag, "_idx0"}, 32'(idx0), 0);
        chk({tag, "_tick0"}, 32'(tick0), 0);
        chk({tag, "_serr0"}, 32'(serr0), 0);
        chk({tag, "_y1"}, 32'(y1), 0);
        chk({tag, "_idx1"}, 32'(idx1), 0);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t       x;
        logic [7:0] a0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("y0", 32'(y0), 32'(x.y0));
                chk("idx0", 32'(idx0), 32'(x.i0));
                chk("tick0", 32'(tick0), 32'(x.t0));
                chk("serr0", 32'(serr0), 32'(x.s0));
                chk("y1", 32'(y1), 32'(x.y1));
                chk("idx1", 32'(idx1), 32'(x.i1));
                chk("tick1", 32'(tick1), 32'(x.t1));
                chk("serr1", 32'(serr1), 32'(x.s1));
                a0 = ~y0;
                chk("onehot0",
                    32'($countones(a0) <= 1 && a0[7:6] == 2'b00), 1);
                chk("onehot1", 32'($countones(y1) <= 1), 1);
            end
        end
    end

    initial begin
        bit e;
        bit a;
        int s;
        rst_n = 1'b1;
        en    = 1'b0;
        auto  = 1'b0;
        sel   = 3'd0;
        m0    = mreset();
        m1    = mreset();
        #3;
        rst_n = 1'b0;
        #1;
        reset_chk("rst");
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        repeat (6) cyc(1, 0, 3);
        repeat (4) cyc(1, 0, 7);
        repeat (30) cyc(1, 1, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (12) cyc(1, 1, 0);
        for (int i = 0; i < 8 && m0.ph != 3; i++) cyc(1, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (6) cyc(1, 1, 0);
        repeat (8) cyc(1, 0, 1);

        a = 1'b0;
        s = 0;
        repeat (300) begin
            e = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) a = !a;
            if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 7);
            cyc(e, a, s);
        end
        drain();

        @(posedge clk);
        #3;
        en    = 1'b0;
        auto  = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_chk("midrst");
        m0 = mreset();
        m1 = mreset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        a = 1'b0;
        s = 2;
        repeat (40) begin
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) a = !a;
            if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 7);
            cyc(e, a, s);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder for the Basys3 lab designs.
- Two operating modes:
  - Manual: decodes a select input, like a classic 3-8 decoder but clocked.
  - Auto-scan: an internal prescaler and index counter step through the outputs, for multiplexed 7-segment anodes or LED scanning.
- Programmable blanking between output changes prevents ghosting.
- Sits between display/control logic and board pins.

Parameters:
- SEL_W, 3, width of select/index; output width is 2**SEL_W.
- NUM_OUT, 8, number of outputs used in scan (2 ≤ NUM_OUT ≤ 2**SEL_W); index wraps at NUM_OUT-1.
- CLK_DIV, 100000, clock cycles per scan step (≥ 1).
- BLANK_CYC, 16, inactive cycles inserted after every index change (0 = none).
- ACTIVE_LOW, 1, 1 = selected output driven 0 and others 1; 0 = inverse polarity.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = decoder active; 0 = all outputs inactive.
- auto  in  1  1 = auto-scan mode; 0 = manual mode.
- sel  in  SEL_W  manual-mode select.
- y  out  2**SEL_W  registered one-hot decode, polarity per ACTIVE_LOW.
- idx  out  SEL_W  current index.
- tick  out  1  one-cycle pulse on each prescaler wrap (auto mode only).
- sel_err  out  1  one-cycle pulse when manual sel ≥ NUM_OUT.

Behaviour:
- Reset (async assert, sync release): state = IDLE, prescaler = 0, idx = 0, y = all inactive (all 1s if ACTIVE_LOW), tick = 0, sel_err = 0.
- States:
  - IDLE: outputs inactive.
  - BLANK: outputs inactive, blank counter running.
  - DRIVE: y = decode(idx).
- Transitions:
  - en = 0 in any state → IDLE next cycle; prescaler and blank counter cleared; idx held.
  - IDLE & en = 1 → BLANK (or DRIVE directly if BLANK_CYC = 0).
  - BLANK → DRIVE after exactly BLANK_CYC cycles in BLANK.
  - DRIVE & change event → BLANK (or stay in DRIVE with the new idx if BLANK_CYC = 0).
- Change events:
  - Auto mode: tick while en = 1. idx ← (idx == NUM_OUT-1) ? 0 : idx+1.
  - Manual mode: sel ≠ idx and sel < NUM_OUT. idx ← sel.
  - Manual sel ≥ NUM_OUT: idx unchanged, sel_err pulses once per cycle in which it holds, state unchanged.
- Prescaler:
  - Counts 0..CLK_DIV-1 only when en = 1 and auto = 1, in every state including BLANK and IDLE exit.
  - tick = 1 for the cycle the count equals CLK_DIV-1; the count then wraps to 0.
  - CLK_DIV = 1: tick is high every enabled auto cycle.
- Mode toggle (auto changes value) while en = 1: prescaler cleared, state → BLANK, idx held; an auto→manual toggle then applies sel on the following cycles.
- Simultaneous events:
  - en = 0 has priority over everything.
  - A tick during BLANK advances idx and restarts the blank count.
- Timing: y, idx and state update on the same clk edge, so y reflects idx with zero added latency relative to state. Manual sel change → BLANK on the next edge → DRIVE BLANK_CYC cycles later.
- Width rules:
  - Prescaler width is clog2(CLK_DIV), minimum 1.
  - Blank counter width is clog2(BLANK_CYC+1).
  - No output ever has more than one active bit.
  - Outputs ≥ NUM_OUT are never activated.
- Reset mid-operation returns all outputs to their reset values immediately.

Decomposition:
- Shared package scan_pkg holds:
  - state encoding localparams (IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2);
  - function onehot_decode(idx, active_low);
  - clog2 helper.
- One natural sub-module: clk_prescaler (CLK_DIV, en, clear → tick), reusable for the board's other tick generators.
- The FSM and index logic stay in scan_decoder.

Test Plan (SEL_W=3, NUM_OUT=6, CLK_DIV=4, BLANK_CYC=2, ACTIVE_LOW=1):
- Reset with rst_n=0 mid-cycle → y=8'hFF, idx=0, tick=0 immediately (asynchronous).
- en=1, auto=0, sel=3 held → 1 cycle IDLE→BLANK, 2 BLANK cycles y=8'hFF, then y=8'hF7, idx=3.
- Manual sel=7 → sel_err pulses every cycle sel=7, idx stays 3, y stays 8'hF7.
- auto=1, run 30 cycles → tick every 4th cycle; idx 3→4→5→0 (wrap at 5); y=8'hFF for 2 cycles after each step, then y=8'hEF, 8'hDF, 8'hFE.
- en=0 during DRIVE → next cycle y=8'hFF, idx held; en=1 → 2 blank cycles then same output resumes; prescaler restarts from 0.
- Simultaneous tick and en fall → en wins: IDLE, idx unchanged; also check NUM_OUT=8, BLANK_CYC=0 sweep with y changing directly between one-hot values.
